// File: rtl/crf_lite_cfg_master.sv
// crf_lite_cfg_master: AXI4-Lite initiator that writes the start register, polls status until done/irq,
// then reports done or error with a sticky error code.
module crf_lite_cfg_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] START_ADDR = 'h0,
  parameter logic [AXI_DATA_WIDTH-1:0] START_VAL = 'h1,
  parameter logic [AXI_ADDR_WIDTH-1:0] STATUS_ADDR = 'h4,
  parameter logic [AXI_DATA_WIDTH-1:0] DONE_MASK = 'h1,
  parameter int POLL_INTERVAL = 16,
  parameter int TIMEOUT = 2**20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_code,
  output logic [AXI_DATA_WIDTH-1:0]   status_rdata,
  input  logic                        interrupt_updone,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp
);
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_POLL, S_RD, S_RD_R, S_DONE, S_ERR} state_t;
  state_t r_state, w_next;
  logic r_aw_pend, r_w_pend, r_irq_seen;
  logic [PW-1:0] r_poll_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [1:0] r_err_code;
  logic [AXI_DATA_WIDTH-1:0] r_status;
  logic w_aw_ok, w_w_ok, w_poll_last, w_timeout, w_rd_done, w_polling;
  assign w_aw_ok     = !r_aw_pend || m_axi_awready;
  assign w_w_ok      = !r_w_pend || m_axi_wready;
  assign w_poll_last = r_poll_cnt == PW'(POLL_INTERVAL - 1);
  assign w_timeout   = r_to_cnt >= TW'(TIMEOUT);
  assign w_rd_done   = (m_axi_rdata & DONE_MASK) != '0;
  assign w_polling   = r_state == S_POLL || r_state == S_RD || r_state == S_RD_R;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = go ? S_WR : S_IDLE;
      S_WR:   w_next = (w_aw_ok && w_w_ok) ? S_WR_B : S_WR;
      S_WR_B: w_next = !m_axi_bvalid ? S_WR_B : (m_axi_bresp == 2'b00) ? S_POLL : S_ERR;
      S_POLL: w_next = r_irq_seen ? S_DONE : w_timeout ? S_ERR : w_poll_last ? S_RD : S_POLL;
      S_RD:   w_next = m_axi_arready ? S_RD_R : S_RD;
      S_RD_R: w_next = !m_axi_rvalid ? S_RD_R : (m_axi_rresp != 2'b00) ? S_ERR :
                       (w_rd_done || r_irq_seen) ? S_DONE : S_POLL;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    busy          = r_state != S_IDLE;
    done          = r_state == S_DONE;
    error         = r_state == S_ERR;
    m_axi_bready  = r_state == S_WR_B;
    m_axi_arvalid = r_state == S_RD;
    m_axi_rready  = r_state == S_RD_R;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_pend  <= 1'b0;
      r_w_pend   <= 1'b0;
      r_irq_seen <= 1'b0;
      r_poll_cnt <= '0;
      r_to_cnt   <= '0;
      r_err_code <= 2'd0;
      r_status   <= '0;
    end else begin
      if (r_state == S_IDLE && go) begin
        r_aw_pend  <= 1'b1;
        r_w_pend   <= 1'b1;
        r_irq_seen <= 1'b0;
        r_err_code <= 2'd0;
      end else begin
        if (m_axi_awready) r_aw_pend <= 1'b0;
        if (m_axi_wready) r_w_pend <= 1'b0;
        if (w_polling && interrupt_updone) r_irq_seen <= 1'b1;
      end
      r_poll_cnt <= (r_state == S_POLL) ? r_poll_cnt + 1'b1 : '0;
      // Counter saturates at TIMEOUT so a long RD/RD_R stall cannot wrap it.
      r_to_cnt <= (r_state == S_WR_B) ? '0 : (w_polling && !w_timeout) ? r_to_cnt + 1'b1 : r_to_cnt;
      if (w_next == S_ERR && r_state != S_ERR)
        r_err_code <= (r_state == S_WR_B) ? 2'd1 : (r_state == S_RD_R) ? 2'd2 : 2'd3;
      if (r_state == S_RD_R && m_axi_rvalid) r_status <= m_axi_rdata;
    end
  end
  assign err_code      = r_err_code;
  assign status_rdata  = r_status;
  assign m_axi_awvalid = r_aw_pend;
  assign m_axi_wvalid  = r_w_pend;
  assign m_axi_awaddr  = START_ADDR;
  assign m_axi_wdata   = START_VAL;
  assign m_axi_araddr  = STATUS_ADDR;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wstrb   = '1;
endmodule
